mux_nand: RTL and testbench

//   4:1 multiplexer built only from 2-, 3- and 4-input NAND gates, with an extra registered copy of the output.

---
 rtl/mux_nand.sv | 84 ++++++++
 tb/tb_mux_nand.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mux_nand.sv
// mux_nand: WIDTH-bit 4:1 multiplexer built only from NAND terms, plus a
// registered copy of the output. Select index is {s0,s1}, s0 is the MSB.
// Optional build macro MUX_NAND_CHG_EN adds the registered change flag y_chg.
module mux_nand #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y,
`ifdef MUX_NAND_CHG_EN
  output logic             y_chg,
`endif
  output logic [WIDTH-1:0] y_q
);

  // Shared select decode: self-NANDs act as inverters for every slice.
  logic w_n0;
  logic w_n1;
  assign w_n0 = ~(s0 & s0);
  assign w_n1 = ~(s1 & s1);

  logic [WIDTH-1:0] w_ta;
  logic [WIDTH-1:0] w_tb;
  logic [WIDTH-1:0] w_tc;
  logic [WIDTH-1:0] w_td;

  // One NAND mux slice per bit: four 3-input product terms into a 4-input NAND.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    assign w_ta[i] = ~(w_n0 & w_n1 & a[i]);
    assign w_tb[i] = ~(w_n0 & s1   & b[i]);
    assign w_tc[i] = ~(s0   & w_n1 & c[i]);
    assign w_td[i] = ~(s0   & s1   & d[i]);
    assign y[i]    = ~(w_ta[i] & w_tb[i] & w_tc[i] & w_td[i]);
  end

  logic [WIDTH-1:0] r_yq;

  // Registered copy of y; async reset clears it immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_yq <= '0;
    else     r_yq <= y;
  end

  assign y_q = r_yq;

`ifdef MUX_NAND_CHG_EN
  // Per-bit XOR of incoming y against the held y_q, four NANDs each.
  logic [WIDTH-1:0] w_xt;
  logic [WIDTH-1:0] w_xp;
  logic [WIDTH-1:0] w_xq;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_nx;
  logic             w_chg;

  for (genvar i = 0; i < WIDTH; i++) begin : g_diff
    assign w_xt[i] = ~(y[i] & r_yq[i]);
    assign w_xp[i] = ~(y[i] & w_xt[i]);
    assign w_xq[i] = ~(r_yq[i] & w_xt[i]);
    assign w_x[i]  = ~(w_xp[i] & w_xq[i]);
    assign w_nx[i] = ~(w_x[i] & w_x[i]);
  end

  // OR of the differences: NAND of the inverted difference bits.
  assign w_chg = ~(&w_nx);

  logic r_chg;

  // Flag is high for the cycle after y_q takes a new value; first capture
  // after reset compares against the cleared 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_chg <= 1'b0;
    else     r_chg <= w_chg;
  end

  assign y_chg = r_chg;
`endif

endmodule

// File: tb/tb_mux_nand.sv
// Directed bench for mux_nand: a WIDTH=1 instance for the combinational and
// registered paths, a WIDTH=8 instance for the byte sweep and (when built with
// MUX_NAND_CHG_EN) the change flag.
module tb_mux_nand;

  logic       clk = 1'b0;
  bit         clk_en = 1'b0;
  logic       rst;
  logic       s0, s1;
  logic [0:0] a1, b1, c1, d1, y1, yq1;
  logic [7:0] a8, b8, c8, d8, y8, yq8;
`ifdef MUX_NAND_CHG_EN
  logic       chg1, chg8;
`endif

  int checks = 0;
  int failures = 0;

  always #5 if (clk_en) clk = ~clk;

  mux_nand #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .s0(s0), .s1(s1),
    .a(a1), .b(b1), .c(c1), .d(d1), .y(y1),
`ifdef MUX_NAND_CHG_EN
    .y_chg(chg1),
`endif
    .y_q(yq1)
  );

  mux_nand #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .s0(s0), .s1(s1),
    .a(a8), .b(b8), .c(c8), .d(d8), .y(y8),
`ifdef MUX_NAND_CHG_EN
    .y_chg(chg8),
`endif
    .y_q(yq8)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] e;
    logic [3:0] dv;
    logic [1:0] sel;
    logic [5:0] kv;
    logic [7:0] bytes [4];
    logic [7:0] prev;
    rst = 1'b1;
    {s0, s1} = 2'b00;
    {a1, b1, c1, d1} = 4'b0;
    {a8, b8, c8, d8} = '0;
    #3;
    chk("rst_yq_noclk", yq1, 8'h00);
    chk("rst_yq8_noclk", yq8, 8'h00);

    // Directed single-bit vectors.
    {s0, s1} = 2'b00; {a1, b1, c1, d1} = 4'b1000; #1; chk("sel_a_1", y1, 8'h01);
    a1 = 1'b0; #1; chk("sel_a_0", y1, 8'h00);
    {s0, s1} = 2'b01; {a1, b1, c1, d1} = 4'b0100; #1; chk("sel_b_1", y1, 8'h01);
    {a1, b1, c1, d1} = 4'b1011; #1; chk("sel_b_0", y1, 8'h00);
    {s0, s1} = 2'b10; {a1, b1, c1, d1} = 4'b0010; #1; chk("sel_c_1", y1, 8'h01);
    {a1, b1, c1, d1} = 4'b1101; #1; chk("sel_c_0", y1, 8'h00);
    {s0, s1} = 2'b11; {a1, b1, c1, d1} = 4'b0001; #1; chk("sel_d_1", y1, 8'h01);
    {a1, b1, c1, d1} = 4'b1110; #1; chk("sel_d_0", y1, 8'h00);

    // Exhaustive over {s0,s1,a,b,c,d}; expected picks the indexed data bit.
    for (int k = 0; k < 64; k++) begin
      kv = k[5:0];
      {s0, s1, a1, b1, c1, d1} = kv;
      #1;
      sel = kv[5:4];
      dv  = {kv[0], kv[1], kv[2], kv[3]};  // dv[0]=a .. dv[3]=d
      e   = {7'b0, dv[sel]};
      chk($sformatf("exh_%0d", k), y1, e);
    end

    // Registered path: held at 0 through clock edges while rst=1.
    {s0, s1} = 2'b00; {a1, b1, c1, d1} = 4'b1000; #1;
    clk_en = 1'b1;
    tick(); tick();
    chk("yq_held_in_rst", yq1, 8'h00);
    chk("y_tracks_in_rst", y1, 8'h01);
    @(negedge clk); rst = 1'b0; #1;
    chk("yq_before_first_edge", yq1, 8'h00);
    tick();
    chk("yq_first_capture", yq1, 8'h01);
    a1 = 1'b0; #1;
    chk("yq_holds_between_edges", yq1, 8'h01);
    tick();
    chk("yq_capture_0", yq1, 8'h00);
    a1 = 1'b1;
    tick();
    chk("yq_capture_1", yq1, 8'h01);

    // Async reset between edges.
    @(negedge clk); #2; rst = 1'b1; #1;
    chk("async_rst_yq", yq1, 8'h00);
    chk("async_rst_y", y1, 8'h01);
    tick();
    chk("async_rst_hold", yq1, 8'h00);

    // WIDTH=8 sweep.
    a8 = 8'hA5; b8 = 8'h5A; c8 = 8'hFF; d8 = 8'h00;
    bytes[0] = 8'hA5; bytes[1] = 8'h5A; bytes[2] = 8'hFF; bytes[3] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      {s0, s1} = k[1:0]; #1;
      chk($sformatf("w8_sel%0d", k), y8, bytes[k]);
    end

    // Registered sweep with change flag; each select held for two edges.
    {s0, s1} = 2'b00;
    @(negedge clk); rst = 1'b0;
    prev = 8'h00;
    for (int k = 0; k < 4; k++) begin
      {s0, s1} = k[1:0];
      tick();
      chk($sformatf("w8_yq_sel%0d", k), yq8, bytes[k]);
`ifdef MUX_NAND_CHG_EN
      chk($sformatf("w8_chg_sel%0d", k), {7'b0, chg8}, {7'b0, bytes[k] != prev});
`endif
      tick();
      chk($sformatf("w8_yq_hold%0d", k), yq8, bytes[k]);
`ifdef MUX_NAND_CHG_EN
      chk($sformatf("w8_chg_hold%0d", k), {7'b0, chg8}, 8'h00);
`endif
      prev = bytes[k];
    end
`ifdef MUX_NAND_CHG_EN
    // Back to a: change after d=00 must flag again, then clear with rst.
    {s0, s1} = 2'b00;
    tick();
    chk("w8_chg_back_a", {7'b0, chg8}, 8'h01);
    #2; rst = 1'b1; #1;
    chk("w8_chg_async_rst", {7'b0, chg8}, 8'h00);
    @(negedge clk); rst = 1'b0;
`endif

    clk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
